// File: rtl/vector_element_queue_pkg.sv
// Shared vector types: element offset, queue entry layout and default lane count.
package vector_element_queue_pkg;

    localparam int OFFSET_W    = 16;
    localparam int VELEM_LANES = 2;

    typedef logic [OFFSET_W-1:0] offset_t;

    typedef struct packed {
        offset_t                offset;
        logic                   last;
        logic [VELEM_LANES-1:0] lane_mask;
    } velem_entry_t;

endpackage

// File: rtl/vector_element_queue_lane_mask_gen.sv
// Per-lane active mask: lane i is active when offset + i < vl (32-bit unsigned).
module velem_lane_mask_gen
    import vector_element_queue_pkg::*;
#(
    parameter int LANES = VELEM_LANES
) (
    input  offset_t           offset,
    input  logic [31:0]       vl,
    output logic [LANES-1:0]  mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (32'(offset) + 32'(i)) < vl;
        end
    end

endmodule

// File: rtl/vector_element_queue.sv
// Element-group FIFO between the element counter and the execute lanes.
// Optional same-cycle bypass when empty: VECTOR_ELEMENT_QUEUE_BYPASS_EN.
module vector_element_queue
    import vector_element_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = VELEM_LANES
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push,
    input  offset_t                    push_offset,
    input  logic                       push_last,
    input  logic [31:0]                vl,
    input  logic                       flush,
    input  logic                       pop_ready,
    output logic                       pop_valid,
    output offset_t                    pop_offset,
    output logic                       pop_last,
    output logic [LANES-1:0]           pop_lane_mask,
    output logic                       stall,
    output logic                       busy_ex,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic             ovf;
    offset_t          off_q  [DEPTH];
    logic             last_q [DEPTH];
    logic [LANES-1:0] mask_q [DEPTH];

    logic [LANES-1:0] push_mask;
    logic             full;
    logic             empty;
    logic             byp;
    logic             wr;
    logic             rd;

    velem_lane_mask_gen #(.LANES(LANES)) u_mask (
        .offset (push_offset),
        .vl     (vl),
        .mask   (push_mask)
    );

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

`ifdef VECTOR_ELEMENT_QUEUE_BYPASS_EN
    assign byp = empty & push & pop_ready;
`else
    assign byp = 1'b0;
`endif

    assign wr = push & ~full & ~byp & ~flush;
    assign rd = ~empty & pop_ready & ~flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                off_q[i]  <= '0;
                last_q[i] <= 1'b0;
                mask_q[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push & full)
                ovf <= 1'b1;
            if (wr) begin
                off_q[tail]  <= push_offset;
                last_q[tail] <= push_last;
                mask_q[tail] <= push_mask;
                tail         <= tail + 1'b1;
            end
            if (rd)
                head <= head + 1'b1;
            unique case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head fields read as zero whenever nothing is presented.
    always_comb begin
        pop_valid     = ~empty;
        pop_offset    = empty ? '0 : off_q[head];
        pop_last      = empty ? 1'b0 : last_q[head];
        pop_lane_mask = empty ? '0 : mask_q[head];
`ifdef VECTOR_ELEMENT_QUEUE_BYPASS_EN
        if (empty && push) begin
            pop_valid     = 1'b1;
            pop_offset    = push_offset;
            pop_last      = push_last;
            pop_lane_mask = push_mask;
        end
`endif
    end

    assign stall    = full;
    assign busy_ex  = ~empty;
    assign count    = cnt;
    assign overflow = ovf;

endmodule

// File: tb/tb_vector_element_queue.sv
// Directed bench for vector_element_queue with a queue-based reference model.
module tb_vector_element_queue;
    import vector_element_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int LANES = 2;

    logic              clk;
    logic              nrst;
    logic              push;
    offset_t           push_offset;
    logic              push_last;
    logic [31:0]       vl;
    logic              flush;
    logic              pop_ready;
    logic              pop_valid;
    offset_t           pop_offset;
    logic              pop_last;
    logic [LANES-1:0]  pop_lane_mask;
    logic              stall;
    logic              busy_ex;
    logic [2:0]        count;
    logic              overflow;

    vector_element_queue #(.DEPTH(DEPTH), .LANES(LANES)) dut (
        .CLK           (clk),
        .nRST          (nrst),
        .push          (push),
        .push_offset   (push_offset),
        .push_last     (push_last),
        .vl            (vl),
        .flush         (flush),
        .pop_ready     (pop_ready),
        .pop_valid     (pop_valid),
        .pop_offset    (pop_offset),
        .pop_last      (pop_last),
        .pop_lane_mask (pop_lane_mask),
        .stall         (stall),
        .busy_ex       (busy_ex),
        .count         (count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned     off;
        bit              last;
        bit [LANES-1:0]  m;
    } ment_t;

    ment_t mq[$];
    bit    movf;

    function automatic bit [LANES-1:0] mk(input int unsigned off, input int unsigned v);
        bit [LANES-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i] = (longint'(off) + longint'(i)) < longint'(v);
        return r;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            movf = 1'b0;
        end else if (flush) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            int  sz;
            bit  popped;
            bit  keep;
            ment_t e;
            sz     = mq.size();
            popped = (sz > 0) && pop_ready;
            keep   = push;
            if (push && sz == DEPTH) begin
                movf = 1'b1;
                keep = 1'b0;
            end
`ifdef VECTOR_ELEMENT_QUEUE_BYPASS_EN
            if (push && sz == 0 && pop_ready)
                keep = 1'b0;
`endif
            if (popped)
                void'(mq.pop_front());
            if (keep) begin
                e.off  = push_offset;
                e.last = push_last;
                e.m    = mk(push_offset, vl);
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        bit    ev;
        ment_t h;
        ev = mq.size() > 0;
`ifdef VECTOR_ELEMENT_QUEUE_BYPASS_EN
        ev = ev || (push === 1'b1);
`endif
        chk("pop_valid", 32'(pop_valid), 32'(ev));
        if (ev) begin
            if (mq.size() > 0) begin
                h = mq[0];
            end else begin
                h.off  = push_offset;
                h.last = push_last;
                h.m    = mk(push_offset, vl);
            end
            chk("pop_offset", 32'(pop_offset), h.off);
            chk("pop_last", 32'(pop_last), 32'(h.last));
            chk("pop_lane_mask", 32'(pop_lane_mask), 32'(h.m));
        end
        chk("stall", 32'(stall), 32'(mq.size() == DEPTH));
        chk("busy_ex", 32'(busy_ex), 32'(mq.size() > 0));
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(movf));
    end

    task automatic drive(input bit p, input int unsigned off, input bit lst,
                         input int unsigned v, input bit fl, input bit rdy);
        @(posedge clk);
        #1;
        push        = p;
        push_offset = offset_t'(off);
        push_last   = lst;
        vl          = v;
        flush       = fl;
        pop_ready   = rdy;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    initial begin
        nrst        = 1'b0;
        push        = 1'b0;
        push_offset = '0;
        push_last   = 1'b0;
        vl          = 32'd0;
        flush       = 1'b0;
        pop_ready   = 1'b0;

        // reset state
        at_neg();
        chk("rst_valid", 32'(pop_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy", 32'(busy_ex), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_offset", 32'(pop_offset), 0);
        chk("rst_last", 32'(pop_last), 0);
        chk("rst_mask", 32'(pop_lane_mask), 0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // single push, one-cycle latency
        drive(1, 0, 0, 5, 0, 0);
        drive(0, 0, 0, 5, 0, 0);
        at_neg();
        chk("t1_valid", 32'(pop_valid), 1);
        chk("t1_mask", 32'(pop_lane_mask), 32'h3);
        chk("t1_count", 32'(count), 1);
        drive(0, 0, 0, 5, 0, 1);
        drive(0, 0, 0, 5, 0, 0);
        at_neg();
        chk("t1_drain", 32'(count), 0);

        // in-order drain, tail group partially active
        drive(1, 0, 0, 5, 0, 0);
        drive(1, 2, 0, 5, 0, 0);
        drive(1, 4, 1, 5, 0, 0);
        drive(0, 0, 0, 5, 0, 1);
        drive(0, 0, 0, 5, 0, 1);
        drive(0, 0, 0, 5, 0, 1);
        at_neg();
        chk("t2_offset", 32'(pop_offset), 4);
        chk("t2_mask", 32'(pop_lane_mask), 32'h1);
        chk("t2_last", 32'(pop_last), 1);
        drive(0, 0, 0, 5, 0, 0);
        at_neg();
        chk("t2_busy", 32'(busy_ex), 0);

        // fill, then overflow
        drive(1, 0, 0, 5, 0, 0);
        drive(1, 2, 0, 5, 0, 0);
        drive(1, 4, 0, 5, 0, 0);
        drive(1, 6, 1, 5, 0, 0);
        drive(1, 8, 0, 5, 0, 0);
        at_neg();
        chk("t3_stall", 32'(stall), 1);
        chk("t3_count", 32'(count), 4);
        drive(0, 0, 0, 5, 0, 0);
        at_neg();
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_count2", 32'(count), 4);

        // full: push and pop together, push dropped
        drive(1, 10, 0, 5, 0, 1);
        drive(0, 0, 0, 5, 0, 0);
        at_neg();
        chk("t4_count", 32'(count), 3);
        chk("t4_stall", 32'(stall), 0);
        chk("t4_offset", 32'(pop_offset), 2);

        // flush wins over concurrent push/pop
        drive(1, 12, 0, 5, 1, 1);
        drive(0, 0, 0, 5, 0, 0);
        at_neg();
        chk("t5_count", 32'(count), 0);
        chk("t5_valid", 32'(pop_valid), 0);
        chk("t5_ovf", 32'(overflow), 0);

        // empty queue, push with ready
        drive(1, 2, 0, 3, 0, 1);
        at_neg();
`ifdef VECTOR_ELEMENT_QUEUE_BYPASS_EN
        chk("t6_valid", 32'(pop_valid), 1);
        chk("t6_mask", 32'(pop_lane_mask), 32'h1);
        chk("t6_offset", 32'(pop_offset), 2);
        chk("t6_count", 32'(count), 0);
        drive(0, 0, 0, 3, 0, 0);
        at_neg();
        chk("t6_count2", 32'(count), 0);
`else
        chk("t6_valid", 32'(pop_valid), 0);
        drive(0, 0, 0, 3, 0, 0);
        at_neg();
        chk("t6_count2", 32'(count), 1);
        chk("t6_mask", 32'(pop_lane_mask), 32'h1);
        drive(0, 0, 0, 3, 0, 1);
`endif
        drive(0, 0, 0, 3, 0, 0);

        // asynchronous reset mid-operation
        drive(1, 0, 0, 9, 0, 0);
        drive(1, 2, 0, 9, 0, 0);
        drive(1, 4, 0, 9, 0, 0);
        #2;
        nrst = 1'b0;
        push = 1'b0;
        #1;
        chk("t7_count", 32'(count), 0);
        chk("t7_valid", 32'(pop_valid), 0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // streaming mix, checked every cycle by the model
        for (int i = 0; i < 60; i++) begin
            drive(i % 3 != 0, (i * 2) & 16'hffff, i % 5 == 4,
                  i % 9, i == 31, i % 4 != 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        repeat (DEPTH + 2) drive(0, 0, 0, 0, 0, 1);
        at_neg();
        chk("end_count", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vector_element_queue.md
# vector_element_queue

Element-group queue between the vector element counter (decode side) and the vector execute lanes. It captures each element-group issue (offset, last flag) from the counter, computes the per-lane active mask against `vl`, and buffers entries in a small FIFO. Entries are drained to execute with a valid/ready handshake. It drives the `stall` and `busy_ex` back-pressure signals that the element counter consumes.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `LANES`, 2: elements per group; offset advances by `LANES` per push.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `push`  in  1  counter issued a group this cycle (`de_en & ~stall`).
- `push_offset`  in  `offset_t`  element offset of the group's lane 0.
- `push_last`  in  1  counter `done`: final group of the instruction.
- `vl`  in  32  active vector length for the instruction in flight.
- `flush`  in  1  `clear`/`ex_return`: discard all entries.
- `pop_ready`  in  1  execute accepts the head entry.
- `pop_valid`  out  1  head entry is valid.
- `pop_offset`  out  `offset_t`  head entry offset.
- `pop_last`  out  1  head entry is the final group.
- `pop_lane_mask`  out  `LANES`  bit i = (`offset + i < vl`).
- `stall`  out  1  queue full; upstream must not push.
- `busy_ex`  out  1  queue non-empty.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: push seen while full.

## Operation
- Storage: `DEPTH` entries of {offset, last, lane_mask}; head/tail pointers of $clog2(DEPTH) bits wrap modulo `DEPTH`; separate occupancy counter.
- Lane mask computed at push: compare `push_offset + i` against `vl` as 32-bit unsigned; `push_offset` zero-extended. Groups with all-zero mask are stored anyway.
- Push accepted iff `push & ~full`; pop occurs iff `pop_valid & pop_ready`.
- Simultaneous push and pop: count unchanged; when full, push still rejected (stall is registered full).
- Push while full: entry dropped, `overflow` set; remains set until `flush` or reset.
- `flush`: head, tail, count, `overflow` cleared next edge; same-cycle push and pop ignored.
- `stall` = (count == DEPTH); `busy_ex` = (count != 0); `pop_valid` = `busy_ex` (absent bypass).
- Head outputs are from storage (no combinational path push→pop outputs without the macro).

## Timing
- Reset: pointers, count 0; `pop_valid`, `stall`, `busy_ex`, `overflow` 0; `pop_offset`, `pop_last`, `pop_lane_mask` 0.
- Latency push→`pop_valid`: 1 cycle (0 with bypass, see Configuration).
- `stall` asserts the cycle after the push that fills the queue; deasserts the cycle after a pop from full.
- Reset asserted mid-operation: all state cleared immediately (asynchronous); in-flight push lost.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `VECTOR_ELEMENT_QUEUE_BYPASS_EN`: when defined and queue empty, a push with `pop_ready` high is presented on pop outputs the same cycle and not stored; `pop_valid` = `busy_ex | push`. Not defined: every entry is stored; minimum one-cycle latency.

## Structure
- `offset_t` from `rv32i_types_pkg`; new `velem_entry_t` struct {offset, last, lane_mask} and `VELEM_LANES` default constant go in the shared vector types package.
- One sub-module: `velem_lane_mask_gen` (combinational offset/vl compare), reused by execute.

## Test plan
- Reset, then push offset 0, last 0, vl 5 → next cycle `pop_valid`=1, `pop_lane_mask`=2'b11, `count`=1.
- Push offsets 0,2,4 (last on 4), vl 5, `pop_ready`=1 → pops in order; offset 4 mask 2'b01, `pop_last`=1; `busy_ex` drops after.
- Four pushes with `pop_ready`=0 → `stall`=1 at count 4; fifth push → `overflow`=1, count stays 4.
- Full queue, push and pop same cycle → push dropped, count 3, `stall` 0 next cycle.
- Three entries, `flush` with concurrent push/pop → next cycle count 0, `pop_valid` 0, `overflow` 0.
- Bypass enabled, empty, push offset 2 vl 3 with `pop_ready`=1 → same-cycle `pop_valid`=1, mask 2'b01, count stays 0.
